// File: rtl/excl_guard_pkg.sv
// Shared definitions for the exclusivity guard monitor: FSM state encoding
// and the legality-rule selectors.
package excl_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  localparam int MODE_AT_MOST_ONE = 0;
  localparam int MODE_EXACTLY_ONE = 1;
  localparam int MODE_AT_MOST_K   = 2;

  localparam int RUN_W = 8;

endpackage

// File: rtl/excl_rule_eval.sv
// Combinational legality rule: popcount of the active-channel vector
// compared against the selected MODE limit.
module excl_rule_eval
  import excl_guard_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int MODE = MODE_AT_MOST_ONE,
  parameter int KMAX = 2
) (
  input  logic [NCH-1:0] i_act,
  output logic           o_bad
);

  localparam int PW = $clog2(NCH + 1);

  logic [PW-1:0] w_pop;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < NCH; k++) begin
      w_pop = w_pop + PW'(i_act[k]);
    end
  end

  always_comb begin
    o_bad = 1'b0;
    if (MODE == MODE_EXACTLY_ONE) begin
      o_bad = (w_pop != PW'(1));
    end else if (MODE == MODE_AT_MOST_K) begin
      o_bad = (w_pop > PW'(KMAX));
    end else begin
      o_bad = (w_pop > PW'(1));
    end
  end

endmodule

// File: rtl/excl_guard_mon.sv
// Two-stage exclusivity monitor: registers gated requests, judges legality,
// and tracks sticky/counted violations with an IDLE/MONITOR/FAULT FSM.
module excl_guard_mon
  import excl_guard_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int NGRP      = 3,
  parameter int MODE      = MODE_AT_MOST_ONE,
  parameter int KMAX      = 2,
  parameter int FAULT_RUN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             CK,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NCH-1:0]   req,
  input  logic [NGRP-1:0]  grp_a,
  input  logic [NGRP-1:0]  grp_b,
  input  logic             clr,
  output logic             ok,
  output logic             viol_sticky,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [NCH-1:0]   first_viol,
  output logic [1:0]       state
);

  state_t           r_state;
  logic [NCH-1:0]   r_act;
  logic [NGRP-1:0]  r_gact;
  logic             r_ok;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;
  logic [NCH-1:0]   r_first;
  logic [RUN_W-1:0] r_run;

  logic             w_mode_bad;
  logic             w_grp_bad;
  logic             w_illegal;
  logic [RUN_W-1:0] w_run_inc;
  logic             w_trip;
  logic [CNT_W-1:0] w_cnt_inc;

  excl_rule_eval #(
    .NCH  (NCH),
    .MODE (MODE),
    .KMAX (KMAX)
  ) u_rule (
    .i_act (r_act),
    .o_bad (w_mode_bad)
  );

  // Any active channel needs every group pair to have at least one member up.
  assign w_grp_bad = (|r_act) && !(&r_gact);
  assign w_illegal = w_mode_bad | w_grp_bad;

  assign w_run_inc = (r_run == RUN_W'(FAULT_RUN)) ? r_run : r_run + RUN_W'(1);
  assign w_trip    = w_illegal && (w_run_inc == RUN_W'(FAULT_RUN));
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge CK) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_act    <= '0;
      r_gact   <= '0;
      r_ok     <= 1'b1;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_first  <= '0;
      r_run    <= '0;
    end else begin
      r_act  <= en ? req : '0;
      r_gact <= en ? (grp_a | grp_b) : '0;
      if (clr) begin
        // The coincident evaluation is dropped entirely.
        r_ok     <= 1'b1;
        r_sticky <= 1'b0;
        r_cnt    <= '0;
        r_first  <= '0;
        r_run    <= '0;
        r_state  <= (r_state != ST_FAULT && en) ? ST_MONITOR : ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_ok  <= 1'b1;
            r_run <= '0;
            if (en) r_state <= ST_MONITOR;
          end
          ST_MONITOR: begin
            if (w_illegal) begin
              r_sticky <= 1'b1;
              r_cnt    <= w_cnt_inc;
              if (!r_sticky) r_first <= r_act;
              r_run    <= w_run_inc;
            end else begin
              r_run <= '0;
            end
            // Tripping wins over a simultaneous en drop.
            if (w_trip) begin
              r_state <= ST_FAULT;
              r_ok    <= 1'b1;
            end else if (!en) begin
              r_state <= ST_IDLE;
              r_run   <= '0;
              r_ok    <= 1'b1;
            end else begin
              r_ok <= ~w_illegal;
            end
          end
          ST_FAULT: begin
            r_ok <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
            r_ok    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ok          = r_ok;
  assign viol_sticky = r_sticky;
  assign viol_cnt    = r_cnt;
  assign first_viol  = r_first;
  assign state       = r_state;

endmodule
